nf_instr_fetch: RTL and testbench

//  Instruction fetch unit: supplier of instruction words to nf_control_unit and the register file.

---
 rtl/nf_instr_fetch.sv | 131 +++++++++++++
 tb/tb_nf_instr_fetch.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf_instr_fetch.sv
// Instruction fetch: PC, single-outstanding req/gnt/rvalid memory handshake,
// registered instruction word with decoded field slices.
module nf_instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic        drop_q, drop_d;
    logic        redirect;
    logic [1:0]  tgt_lo_unused;

    assign tgt_lo_unused = branch_target[1:0];
    assign redirect      = branch_taken && (state_q != BOOT);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        drop_d   = drop_q;
        imem_req = 1'b0;

        if (valid_q && !stall) begin
            valid_d = 1'b0;
        end

        case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                imem_req = !stall;
                if (imem_req && imem_gnt) begin
                    state_d = WAIT;
                    drop_d  = redirect;
                end
            end
            WAIT: begin
                if (redirect) begin
                    // a response arriving with the redirect is simply discarded
                    drop_d  = !imem_rvalid;
                    state_d = imem_rvalid ? REQ : WAIT;
                end else if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_q + 32'd4;
                        state_d  = stall ? HOLD : REQ;
                    end
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    state_d = REQ;
                end
            end
            default: state_d = BOOT;
        endcase

        if (redirect) begin
            pc_d    = {branch_target[31:2], 2'b00};
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            instr_q  <= NOP;
            pc_out_q <= RESET_PC;
            valid_q  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign opcode      = instr_q[6:0];
    assign rd          = instr_q[11:7];
    assign funct3      = instr_q[14:12];
    assign rs1         = instr_q[19:15];
    assign rs2         = instr_q[24:20];
    assign funct7      = instr_q[31:25];

endmodule

// File: tb/tb_nf_instr_fetch.sv
// Bench for nf_instr_fetch: field-decode vector table, directed corner
// sequences, and a randomized run against a transaction-level fetch model.
module tb_nf_instr_fetch;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    nf_instr_fetch #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int edges = 0;

    typedef struct {
        int          gw;
        int          rl;
        logic [31:0] data;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
    } vec_t;

    vec_t vt[4];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic idle_in();
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " req"}, {31'b0, imem_req}, 32'h0);
        chk({nm, " addr"}, imem_addr, RPC);
        chk({nm, " valid"}, {31'b0, instr_valid}, 32'h0);
        chk({nm, " instr"}, instr, 32'h13);
        chk({nm, " pc_out"}, pc_out, RPC);
        chk({nm, " opcode"}, {25'b0, opcode}, 32'h13);
        chk({nm, " fields"}, {rd, funct3, rs1, rs2, funct7}, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_in();
        tick();
        tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        edges = 0;
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk({nm, " req seen"}, {31'b0, imem_req}, 32'h1);
    endtask

    task automatic fetch(input int gw, input int rl, input logic [31:0] d,
                         input logic stall_load, input string nm);
        logic [31:0] a;
        wait_req(nm);
        a = imem_addr;
        for (int i = 0; i < gw; i++) begin
            imem_gnt = 1'b0;
            tick();
            chk({nm, " req held"}, {31'b0, imem_req}, 32'h1);
            chk({nm, " addr held"}, imem_addr, a);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        for (int i = 1; i < rl; i++) tick();
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        stall       = stall_load;
        tick();
        imem_rvalid = 1'b0;
    endtask

    logic [31:0] exp_pc, paddr, addr_a, w, prev_instr, prev_pc, held;
    logic        pend, prev_valid, req_a;
    int          dly, loads;

    initial begin
        reset = 1'b1;
        idle_in();
        vt[0] = '{0, 1, 32'h0050_0093, 7'h13, 5'd1,  3'd0, 5'd0,  5'd5,  7'h00};
        vt[1] = '{4, 1, 32'h40B5_0533, 7'h33, 5'd10, 3'd0, 5'd10, 5'd11, 7'h20};
        vt[2] = '{1, 3, 32'hFFFF_FFFF, 7'h7F, 5'd31, 3'd7, 5'd31, 5'd31, 7'h7F};
        vt[3] = '{0, 2, 32'h0000_A103, 7'h03, 5'd2,  3'd2, 5'd1,  5'd0,  7'h00};

        do_reset();
        for (int i = 0; i < 4; i++) begin
            fetch(vt[i].gw, vt[i].rl, vt[i].data, 1'b0, "vec");
            if (i == 0) chk("first valid edge", edges, 32'd3);
            chk("vec valid", {31'b0, instr_valid}, 32'h1);
            chk("vec pc_out", pc_out, RPC + 32'(4 * i));
            chk("vec instr", instr, vt[i].data);
            chk("vec opcode", {25'b0, opcode}, {25'b0, vt[i].op});
            chk("vec rd", {27'b0, rd}, {27'b0, vt[i].rd});
            chk("vec funct3", {29'b0, funct3}, {29'b0, vt[i].f3});
            chk("vec rs1", {27'b0, rs1}, {27'b0, vt[i].rs1});
            chk("vec rs2", {27'b0, rs2}, {27'b0, vt[i].rs2});
            chk("vec funct7", {25'b0, funct7}, {25'b0, vt[i].f7});
            chk("vec next req", {31'b0, imem_req}, 32'h1);
            chk("vec next addr", imem_addr, RPC + 32'(4 * (i + 1)));
        end

        // stall at load: outputs frozen, no request until stall drops
        fetch(0, 1, 32'h0020_8133, 1'b1, "hold");
        for (int i = 0; i < 3; i++) begin
            chk("hold valid", {31'b0, instr_valid}, 32'h1);
            chk("hold instr", instr, 32'h0020_8133);
            chk("hold pc_out", pc_out, 32'h110);
            chk("hold req", {31'b0, imem_req}, 32'h0);
            tick();
        end
        stall = 1'b0;
        tick();
        chk("unhold req", {31'b0, imem_req}, 32'h1);
        chk("unhold addr", imem_addr, 32'h114);
        chk("unhold valid", {31'b0, instr_valid}, 32'h0);

        // redirect coincident with rvalid
        wait_req("br_rv");
        imem_gnt = 1'b1;
        tick();
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b1;
        imem_rdata    = 32'hDEAD_BEEF;
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        tick();
        imem_rvalid  = 1'b0;
        branch_taken = 1'b0;
        chk("br_rv valid", {31'b0, instr_valid}, 32'h0);
        chk("br_rv instr", instr, 32'h0020_8133);
        chk("br_rv addr", imem_addr, 32'h200);
        fetch(0, 1, 32'h0010_0113, 1'b0, "tgt");
        chk("tgt pc_out", pc_out, 32'h200);
        chk("tgt instr", instr, 32'h0010_0113);

        // redirect in WAIT before rvalid: late word dropped
        wait_req("br_wait");
        imem_gnt = 1'b1;
        tick();
        imem_gnt      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        tick();
        branch_taken = 1'b0;
        chk("br_wait req", {31'b0, imem_req}, 32'h0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        tick();
        imem_rvalid = 1'b0;
        chk("drop valid", {31'b0, instr_valid}, 32'h0);
        chk("drop instr", instr, 32'h0010_0113);
        chk("drop req", {31'b0, imem_req}, 32'h1);
        chk("drop addr", imem_addr, 32'h200);
        fetch(0, 1, 32'h0030_0193, 1'b0, "refetch");
        chk("refetch pc_out", pc_out, 32'h200);
        chk("refetch instr", instr, 32'h0030_0193);

        // unaligned target and PC wrap
        wait_req("align");
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0203;
        tick();
        chk("align addr", imem_addr, 32'h200);
        chk("align req", {31'b0, imem_req}, 32'h1);
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        chk("wrap req addr", imem_addr, 32'hFFFF_FFFC);
        fetch(0, 1, 32'h0000_0013, 1'b0, "wrap");
        chk("wrap pc_out", pc_out, 32'hFFFF_FFFC);
        chk("wrap next addr", imem_addr, 32'h0);

        // reset while waiting; stale response afterwards ignored
        wait_req("rst");
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        reset    = 1'b1;
        #1;
        chk_reset_vals("async rst");
        tick();
        reset = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        chk("stale valid", {31'b0, instr_valid}, 32'h0);
        chk("stale instr", instr, 32'h13);
        chk("restart addr", imem_addr, RPC);
        fetch(0, 1, 32'h0050_0093, 1'b0, "restart");
        chk("restart pc_out", pc_out, RPC);
        chk("restart instr", instr, 32'h0050_0093);

        // randomized run against the fetch-stream model
        do_reset();
        exp_pc     = RPC;
        pend       = 1'b0;
        paddr      = 32'h0;
        dly        = 0;
        loads      = 0;
        prev_valid = 1'b0;
        prev_instr = instr;
        prev_pc    = pc_out;
        for (int c = 0; c < 3000; c++) begin
            stall         = ($urandom_range(3) == 0);
            branch_taken  = (c >= 1) && ($urandom_range(11) == 0);
            branch_target = ($urandom_range(7) == 0)
                          ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                          : (32'h100 + 32'($urandom_range(1023)));
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pend) begin
                if (dly == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = memfn(paddr);
                end else begin
                    dly--;
                end
            end
            #1;
            req_a    = imem_req;
            addr_a   = imem_addr;
            imem_gnt = req_a && ($urandom_range(2) != 0);
            tick();
            if (imem_rvalid) pend = 1'b0;
            if (req_a && imem_gnt) begin
                pend  = 1'b1;
                paddr = addr_a;
                dly   = int'($urandom_range(2));
            end
            if (branch_taken) exp_pc = {branch_target[31:2], 2'b00};
            if (prev_valid) begin
                if (branch_taken || !stall) begin
                    chk("rnd consume", {31'b0, instr_valid}, 32'h0);
                end else begin
                    chk("rnd stall valid", {31'b0, instr_valid}, 32'h1);
                    chk("rnd stall instr", instr, prev_instr);
                    chk("rnd stall pc", pc_out, prev_pc);
                end
            end else if (instr_valid) begin
                w = memfn(exp_pc);
                loads++;
                chk("rnd pc_out", pc_out, exp_pc);
                chk("rnd instr", instr, w);
                chk("rnd fields", {opcode, rd, funct3, rs1, rs2, funct7},
                    {w[6:0], w[11:7], w[14:12], w[19:15], w[24:20], w[31:25]});
                exp_pc = exp_pc + 32'd4;
            end
            if (imem_req) chk("rnd req addr", imem_addr, exp_pc);
            prev_valid = instr_valid;
            prev_instr = instr;
            prev_pc    = pc_out;
        end
        held = 32'(loads > 200);
        chk("rnd progress", held, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
